rgb_to_axis_video: RTL and testbench



---
 rtl/rgb_to_axis_video.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_rgb_to_axis_video.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_to_axis_video.sv
// ---------------------------------------------------------------------------
// rgb_to_axis_video
//
// Repacks a cke-qualified RGB888 raster stream (hs/vs/de/dat) into an
// AXI4-Stream video stream. tuser flags the first pixel of a frame and tlast
// the last pixel of each line. A small first-word-fall-through FIFO absorbs
// consumer backpressure. The block also measures the active line width and
// the frame height, and raises sticky flags for dropped pixels and for lines
// whose width differs from the previous line of the same frame.
//
// Ports:
//   clk            pixel clock
//   rst_n          asynchronous active-low reset
//   cke            input sample qualifier (rgb_* sampled only when 1)
//   rgb_hs         horizontal sync (lines are delimited by rgb_de instead)
//   rgb_vs         vertical sync, active-high
//   rgb_de         active-video enable
//   rgb_dat        pixel {R, G, B}
//   m_axis_tdata   output pixel, same packing as rgb_dat
//   m_axis_tvalid  output beat valid
//   m_axis_tready  consumer ready
//   m_axis_tuser   first pixel of frame
//   m_axis_tlast   last pixel of line
//   line_width     de=1 samples in the last completed line
//   frame_height   lines counted in the last completed frame
//   width_err      sticky: line width changed within a frame
//   ovf            sticky: pixel dropped because the FIFO was full
//   clr_err        synchronous clear of width_err and ovf
// ---------------------------------------------------------------------------
module rgb_to_axis_video #(
    parameter int FIFO_AW = 4,
    parameter int CNT_W   = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cke,
    input  logic             rgb_hs,
    input  logic             rgb_vs,
    input  logic             rgb_de,
    input  logic [23:0]      rgb_dat,
    output logic [23:0]      m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tuser,
    output logic             m_axis_tlast,
    output logic [CNT_W-1:0] line_width,
    output logic [CNT_W-1:0] frame_height,
    output logic             width_err,
    output logic             ovf,
    input  logic             clr_err
);

    localparam int               DEPTH    = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {
        WAIT_VS = 1'b0,
        ACTIVE  = 1'b1
    } state_t;

    // hs carries no information beyond what de already gives us.
    logic unused_hs;
    assign unused_hs = rgb_hs;

    // -----------------------------------------------------------------------
    // Edge detection on cke samples
    // -----------------------------------------------------------------------
    logic vs_d_reg;
    logic de_d_reg;
    logic vs_rise;
    logic de_fall;

    // Gating with cke keeps undefined inputs on idle cycles from leaking in.
    assign vs_rise = cke & rgb_vs & ~vs_d_reg;
    assign de_fall = cke & ~rgb_de & de_d_reg;

    // -----------------------------------------------------------------------
    // FSM and lookahead hold register
    // -----------------------------------------------------------------------
    state_t      state_reg;
    state_t      state_next;
    logic        hold_valid_reg;
    logic        hold_valid_next;
    logic        hold_sof_reg;
    logic        hold_sof_next;
    logic [23:0] hold_data_reg;
    logic [23:0] hold_data_next;
    logic        sof_pending_reg;
    logic        sof_pending_next;
    logic        push_req;
    logic        push_tlast;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= WAIT_VS;
            hold_valid_reg  <= 1'b0;
            hold_sof_reg    <= 1'b0;
            hold_data_reg   <= '0;
            sof_pending_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            hold_valid_reg  <= hold_valid_next;
            hold_sof_reg    <= hold_sof_next;
            hold_data_reg   <= hold_data_next;
            sof_pending_reg <= sof_pending_next;
        end
    end

    // A pixel is only pushed once the following sample is seen, because only
    // then do we know whether it ended the line (de dropped or a new frame
    // started). That one-sample lookahead is what the hold register is for.
    always_comb begin
        state_next       = state_reg;
        hold_valid_next  = hold_valid_reg;
        hold_sof_next    = hold_sof_reg;
        hold_data_next   = hold_data_reg;
        sof_pending_next = sof_pending_reg;
        push_req         = 1'b0;
        push_tlast       = 1'b0;

        if (cke) begin
            case (state_reg)
                WAIT_VS: begin
                    // Discard everything until a frame boundary so output
                    // never starts with a partial frame.
                    hold_valid_next = 1'b0;
                    if (vs_rise) begin
                        state_next       = ACTIVE;
                        sof_pending_next = 1'b1;
                    end
                end
                ACTIVE: begin
                    push_req   = hold_valid_reg;
                    push_tlast = ~rgb_de | vs_rise;
                    if (rgb_de) begin
                        hold_valid_next  = 1'b1;
                        hold_data_next   = rgb_dat;
                        hold_sof_next    = sof_pending_reg | vs_rise;
                        sof_pending_next = 1'b0;
                    end else begin
                        hold_valid_next  = 1'b0;
                        sof_pending_next = sof_pending_reg | vs_rise;
                    end
                end
                default: begin
                    state_next      = WAIT_VS;
                    hold_valid_next = 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // First-word-fall-through FIFO, entries {tuser, tlast, data}
    // -----------------------------------------------------------------------
    logic [25:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_reg;
    logic [FIFO_AW-1:0] rd_ptr_reg;
    logic [FIFO_AW:0]   count_reg;
    logic               fifo_empty;
    logic               fifo_full;
    logic               pop;
    logic               push_acc;
    logic               push_drop;
    logic [25:0]        push_word;
    logic [25:0]        head_word;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == FULL_CNT);
    assign pop        = ~fifo_empty & m_axis_tready;
    // When full, a same-cycle pop frees the slot being written, so the push
    // can still be taken.
    assign push_acc   = push_req & (~fifo_full | pop);
    assign push_drop  = push_req & fifo_full & ~pop;
    assign push_word  = {hold_sof_reg, push_tlast, hold_data_reg};
    assign head_word  = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr_reg] <= push_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_acc, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Payload is forced to zero while empty so stale or uninitialised array
    // contents never appear on the bus.
    assign m_axis_tvalid = ~fifo_empty;
    assign m_axis_tdata  = fifo_empty ? 24'd0 : head_word[23:0];
    assign m_axis_tlast  = fifo_empty ? 1'b0  : head_word[24];
    assign m_axis_tuser  = fifo_empty ? 1'b0  : head_word[25];

    // -----------------------------------------------------------------------
    // Line / frame measurement and sticky error flags
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] pix_cnt_reg;
    logic [CNT_W-1:0] line_cnt_reg;
    logic [CNT_W-1:0] line_width_reg;
    logic [CNT_W-1:0] frame_height_reg;
    logic [CNT_W-1:0] pix_cnt_inc;
    logic [CNT_W-1:0] line_cnt_inc;
    logic             first_line_reg;
    logic             width_err_reg;
    logic             ovf_reg;
    logic             width_set;

    assign pix_cnt_inc  = (pix_cnt_reg  == CNT_MAX) ? pix_cnt_reg  : pix_cnt_reg  + 1'b1;
    assign line_cnt_inc = (line_cnt_reg == CNT_MAX) ? line_cnt_reg : line_cnt_reg + 1'b1;

    // The first line of a frame has nothing to be compared against.
    assign width_set = de_fall & ~first_line_reg & (pix_cnt_reg != line_width_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d_reg         <= 1'b0;
            de_d_reg         <= 1'b0;
            pix_cnt_reg      <= '0;
            line_cnt_reg     <= '0;
            line_width_reg   <= '0;
            frame_height_reg <= '0;
            // Treat the first line seen after reset as having no reference
            // width, so a stream joined mid-frame does not raise width_err.
            first_line_reg   <= 1'b1;
            width_err_reg    <= 1'b0;
            ovf_reg          <= 1'b0;
        end else begin
            if (cke) begin
                vs_d_reg <= rgb_vs;
                de_d_reg <= rgb_de;

                if (rgb_de) begin
                    pix_cnt_reg <= pix_cnt_inc;
                end else if (de_fall) begin
                    pix_cnt_reg <= '0;
                end

                if (de_fall) begin
                    line_width_reg <= pix_cnt_reg;
                end

                // A line ending on the very sample that starts a new frame
                // still belongs to the frame being closed.
                if (vs_rise) begin
                    frame_height_reg <= de_fall ? line_cnt_inc : line_cnt_reg;
                    line_cnt_reg     <= '0;
                    first_line_reg   <= 1'b1;
                end else if (de_fall) begin
                    line_cnt_reg   <= line_cnt_inc;
                    first_line_reg <= 1'b0;
                end
            end

            // A new event in the same cycle as a clear takes priority.
            width_err_reg <= width_set | (width_err_reg & ~clr_err);
            ovf_reg       <= push_drop | (ovf_reg & ~clr_err);
        end
    end

    assign line_width   = line_width_reg;
    assign frame_height = frame_height_reg;
    assign width_err    = width_err_reg;
    assign ovf          = ovf_reg;

endmodule

// File: tb/tb_rgb_to_axis_video.sv
module tb_rgb_to_axis_video;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cke;
    logic        rgb_hs;
    logic        rgb_vs;
    logic        rgb_de;
    logic [23:0] rgb_dat;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic [11:0] line_width;
    logic [11:0] frame_height;
    logic        width_err;
    logic        ovf;
    logic        clr_err;

    int n_total = 0;
    int n_pass  = 0;

    logic [25:0] beat_q[$];

    logic        lat_v0;
    logic        lat_v1;
    logic [23:0] lat_d1;
    logic        lat_u1;

    always #5 clk = ~clk;

    rgb_to_axis_video #(.FIFO_AW(4), .CNT_W(12)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cke          (cke),
        .rgb_hs       (rgb_hs),
        .rgb_vs       (rgb_vs),
        .rgb_de       (rgb_de),
        .rgb_dat      (rgb_dat),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tlast (m_axis_tlast),
        .line_width   (line_width),
        .frame_height (frame_height),
        .width_err    (width_err),
        .ovf          (ovf),
        .clr_err      (clr_err)
    );

    // Beats accepted by the consumer, captured mid-cycle before the pop edge.
    always @(negedge clk) begin
        if (rst_n && m_axis_tvalid && m_axis_tready) begin
            beat_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
        end
    end

    // One input sample; with tog=1 it is followed by a cke=0 cycle carrying
    // random junk that must be ignored.
    task automatic drive(input logic vs, input logic de, input logic [23:0] dat, input bit tog);
        cke = 1'b1; rgb_vs = vs; rgb_de = de; rgb_dat = dat; rgb_hs = ~de;
        @(posedge clk); #1;
        if (tog) begin
            cke = 1'b0;
            rgb_vs  = 1'($urandom);
            rgb_de  = 1'($urandom);
            rgb_hs  = 1'($urandom);
            rgb_dat = 24'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        cke = 1'b0; rgb_vs = 1'b0; rgb_de = 1'b0; rgb_hs = 1'b0; rgb_dat = '0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // vs pulse, 4 lines x 8 pixels (data line*16+pix), 4 blanking samples,
    // then the next vs rise.
    task automatic send_frame(input bit tog);
        drive(1'b1, 1'b0, 24'd0, tog);
        drive(1'b0, 1'b0, 24'd0, tog);
        drive(1'b0, 1'b0, 24'd0, tog);
        for (int l = 0; l < 4; l++) begin
            for (int p = 0; p < 8; p++) begin
                drive(1'b0, 1'b1, 24'(l * 16 + p), tog);
                if (l == 0 && p == 0) lat_v0 = m_axis_tvalid;
                if (l == 0 && p == 1) begin
                    lat_v1 = m_axis_tvalid; lat_d1 = m_axis_tdata; lat_u1 = m_axis_tuser;
                end
            end
            for (int b = 0; b < 4; b++) drive(1'b0, 1'b0, 24'd0, tog);
        end
        drive(1'b1, 1'b0, 24'd0, tog);
        drive(1'b0, 1'b0, 24'd0, tog);
        idle(6);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cke = 1'b0; rgb_hs = 1'b0; rgb_vs = 1'b0; rgb_de = 1'b0;
        rgb_dat = '0; m_axis_tready = 1'b1; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid got %0b exp 0", m_axis_tvalid); else n_pass++;
        n_total++; if (m_axis_tdata !== 24'd0) $display("FAIL reset_tdata got %h exp 000000", m_axis_tdata); else n_pass++;
        n_total++; if ({m_axis_tuser, m_axis_tlast} !== 2'b00) $display("FAIL reset_user_last got %b exp 00", {m_axis_tuser, m_axis_tlast}); else n_pass++;
        n_total++; if (line_width !== 12'd0) $display("FAIL reset_line_width got %0d exp 0", line_width); else n_pass++;
        n_total++; if (frame_height !== 12'd0) $display("FAIL reset_frame_height got %0d exp 0", frame_height); else n_pass++;
        n_total++; if ({width_err, ovf} !== 2'b00) $display("FAIL reset_flags got %b exp 00", {width_err, ovf}); else n_pass++;
    endtask

    task automatic test_no_vs();
        logic saw_valid;
        saw_valid = 1'b0;
        rst_n = 1'b1;
        for (int l = 0; l < 3; l++) begin
            for (int p = 0; p < 8; p++) begin
                drive(1'b0, 1'b1, 24'(l * 16 + p), 1'b0);
                saw_valid = saw_valid | m_axis_tvalid;
            end
            for (int b = 0; b < 3; b++) begin
                drive(1'b0, 1'b0, 24'd0, 1'b0);
                saw_valid = saw_valid | m_axis_tvalid;
            end
        end
        n_total++; if (saw_valid !== 1'b0) $display("FAIL novs_tvalid got %0b exp 0", saw_valid); else n_pass++;
        n_total++; if (beat_q.size() != 0) $display("FAIL novs_beats got %0d exp 0", beat_q.size()); else n_pass++;
        n_total++; if (line_width !== 12'd8) $display("FAIL novs_line_width got %0d exp 8", line_width); else n_pass++;
    endtask

    task automatic test_frame();
        logic [25:0] exp_b;
        logic [25:0] got_b;
        beat_q.delete();
        m_axis_tready = 1'b1;
        send_frame(1'b0);
        n_total++; if (lat_v0 !== 1'b0) $display("FAIL frame_lat_early got tvalid %0b exp 0", lat_v0); else n_pass++;
        n_total++; if ({lat_v1, lat_u1, lat_d1} !== {1'b1, 1'b1, 24'd0}) $display("FAIL frame_lat_first got v%0b u%0b %h exp v1 u1 000000", lat_v1, lat_u1, lat_d1); else n_pass++;
        n_total++; if (beat_q.size() != 32) $display("FAIL frame_beat_count got %0d exp 32", beat_q.size()); else n_pass++;
        for (int i = 0; i < 32; i++) begin
            exp_b = {(i == 0), (i % 8 == 7), 24'((i / 8) * 16 + i % 8)};
            got_b = (i < beat_q.size()) ? beat_q[i] : 26'h3ffffff;
            n_total++; if (got_b !== exp_b) $display("FAIL frame_beat%0d got %h exp %h", i, got_b, exp_b); else n_pass++;
        end
        n_total++; if (frame_height !== 12'd4) $display("FAIL frame_height got %0d exp 4", frame_height); else n_pass++;
        n_total++; if (line_width !== 12'd8) $display("FAIL frame_line_width got %0d exp 8", line_width); else n_pass++;
        n_total++; if (width_err !== 1'b0) $display("FAIL frame_width_err got %0b exp 0", width_err); else n_pass++;
    endtask

    task automatic test_cke_toggle();
        logic [25:0] exp_b;
        logic [25:0] got_b;
        beat_q.delete();
        m_axis_tready = 1'b1;
        send_frame(1'b1);
        n_total++; if (beat_q.size() != 32) $display("FAIL cke_beat_count got %0d exp 32", beat_q.size()); else n_pass++;
        for (int i = 0; i < 32; i++) begin
            exp_b = {(i == 0), (i % 8 == 7), 24'((i / 8) * 16 + i % 8)};
            got_b = (i < beat_q.size()) ? beat_q[i] : 26'h3ffffff;
            n_total++; if (got_b !== exp_b) $display("FAIL cke_beat%0d got %h exp %h", i, got_b, exp_b); else n_pass++;
        end
        n_total++; if (frame_height !== 12'd4) $display("FAIL cke_frame_height got %0d exp 4", frame_height); else n_pass++;
        n_total++; if (line_width !== 12'd8) $display("FAIL cke_line_width got %0d exp 8", line_width); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [25:0] exp_b;
        logic [25:0] got_b;
        beat_q.delete();
        m_axis_tready = 1'b0;
        for (int p = 0; p < 20; p++) begin
            drive(1'b0, 1'b1, 24'(32'h100 + p), 1'b0);
            if (p == 16) begin
                n_total++; if (ovf !== 1'b0) $display("FAIL bp_ovf_at_full got %0b exp 0", ovf); else n_pass++;
            end
            if (p == 17) begin
                n_total++; if (ovf !== 1'b1) $display("FAIL bp_ovf_first_drop got %0b exp 1", ovf); else n_pass++;
            end
        end
        drive(1'b0, 1'b0, 24'd0, 1'b0);
        drive(1'b0, 1'b0, 24'd0, 1'b0);
        n_total++; if ({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata} !== {3'b110, 24'h000100}) $display("FAIL bp_head got v%0b u%0b l%0b %h exp v1 u1 l0 000100", m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata); else n_pass++;
        idle(5);
        n_total++; if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 24'h000100}) $display("FAIL bp_stable got v%0b %h exp v1 000100", m_axis_tvalid, m_axis_tdata); else n_pass++;
        m_axis_tready = 1'b1;
        idle(20);
        n_total++; if (beat_q.size() != 16) $display("FAIL bp_beat_count got %0d exp 16", beat_q.size()); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            exp_b = {(i == 0), 1'b0, 24'(32'h100 + i)};
            got_b = (i < beat_q.size()) ? beat_q[i] : 26'h3ffffff;
            n_total++; if (got_b !== exp_b) $display("FAIL bp_beat%0d got %h exp %h", i, got_b, exp_b); else n_pass++;
        end
        n_total++; if (ovf !== 1'b1) $display("FAIL bp_ovf_sticky got %0b exp 1", ovf); else n_pass++;
        clr_err = 1'b1;
        drive(1'b0, 1'b0, 24'd0, 1'b0);
        clr_err = 1'b0;
        n_total++; if (ovf !== 1'b0) $display("FAIL bp_ovf_clear got %0b exp 0", ovf); else n_pass++;
    endtask

    task automatic test_width_mismatch();
        int widths[4] = '{8, 8, 7, 5};
        m_axis_tready = 1'b1;
        drive(1'b1, 1'b0, 24'd0, 1'b0);
        drive(1'b0, 1'b0, 24'd0, 1'b0);
        drive(1'b0, 1'b0, 24'd0, 1'b0);
        for (int ln = 0; ln < 4; ln++) begin
            for (int p = 0; p < widths[ln]; p++) drive(1'b0, 1'b1, 24'(32'h300 + p), 1'b0);
            if (ln == 3) clr_err = 1'b1;
            drive(1'b0, 1'b0, 24'd0, 1'b0);
            clr_err = 1'b0;
            if (ln == 1) begin
                n_total++; if ({width_err, line_width} !== {1'b0, 12'd8}) $display("FAIL wm_line2 got err%0b w%0d exp err0 w8", width_err, line_width); else n_pass++;
            end
            if (ln == 2) begin
                n_total++; if ({width_err, line_width} !== {1'b1, 12'd7}) $display("FAIL wm_line3 got err%0b w%0d exp err1 w7", width_err, line_width); else n_pass++;
            end
            if (ln == 3) begin
                n_total++; if ({width_err, line_width} !== {1'b1, 12'd5}) $display("FAIL wm_set_over_clear got err%0b w%0d exp err1 w5", width_err, line_width); else n_pass++;
            end
            drive(1'b0, 1'b0, 24'd0, 1'b0);
            drive(1'b0, 1'b0, 24'd0, 1'b0);
        end
        clr_err = 1'b1;
        drive(1'b0, 1'b0, 24'd0, 1'b0);
        clr_err = 1'b0;
        n_total++; if (width_err !== 1'b0) $display("FAIL wm_clear got %0b exp 0", width_err); else n_pass++;
        idle(10);
        beat_q.delete();
    endtask

    task automatic test_full_push_pop();
        logic [25:0] exp_b;
        logic [25:0] got_b;
        beat_q.delete();
        m_axis_tready = 1'b0;
        for (int p = 0; p < 17; p++) drive(1'b0, 1'b1, 24'(32'h200 + p), 1'b0);
        n_total++; if ({m_axis_tvalid, ovf} !== 2'b10) $display("FAIL full_filled got v%0b ovf%0b exp v1 ovf0", m_axis_tvalid, ovf); else n_pass++;
        m_axis_tready = 1'b1;
        for (int p = 17; p < 24; p++) drive(1'b0, 1'b1, 24'(32'h200 + p), 1'b0);
        drive(1'b0, 1'b0, 24'd0, 1'b0);
        m_axis_tready = 1'b0;
        n_total++; if (beat_q.size() != 8) $display("FAIL full_popped got %0d exp 8", beat_q.size()); else n_pass++;
        n_total++; if (ovf !== 1'b0) $display("FAIL full_ovf got %0b exp 0", ovf); else n_pass++;
        drive(1'b0, 1'b0, 24'd0, 1'b0);
        m_axis_tready = 1'b1;
        idle(20);
        n_total++; if (beat_q.size() != 24) $display("FAIL full_total got %0d exp 24", beat_q.size()); else n_pass++;
        for (int i = 0; i < 24; i++) begin
            exp_b = {1'b0, (i == 23), 24'(32'h200 + i)};
            got_b = (i < beat_q.size()) ? beat_q[i] : 26'h3ffffff;
            n_total++; if (got_b !== exp_b) $display("FAIL full_beat%0d got %h exp %h", i, got_b, exp_b); else n_pass++;
        end
        n_total++; if (m_axis_tvalid !== 1'b0) $display("FAIL full_empty got %0b exp 0", m_axis_tvalid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_no_vs();
        test_frame();
        test_cke_toggle();
        test_backpressure();
        test_width_mismatch();
        test_full_push_pop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
